// File: rtl/boot_pkg.sv
// boot_pkg
//   Shared definitions for the boot sequencer: the FSM state encoding,
//   default array geometry, and a small state-decoding helper.
//   Imported by boot_sequencer and boot_checksum_acc.
package boot_pkg;

    // Default array geometry (overridable through module parameters).
    localparam int DEF_NUM_PROCS = 90;
    localparam int DEF_SEL_W     = 7;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_WORDS     = 16384;
    localparam int DEF_DATA_W    = 32;

    // Width of the optional image checksum.
    localparam int CHECKSUM_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } boot_state_t;

    // The sequencer is busy from the first image read until the array
    // reset is about to be released.
    function automatic logic is_busy(input boot_state_t s);
        return (s == ST_LOAD) || (s == ST_DRAIN) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/boot_checksum_acc.sv
// boot_checksum_acc
//   Running modulo-2^32 sum of every instruction and data word written
//   into the array during a boot.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     clear        - start of a new boot; zeroes the sum
//     en           - a boot write happens this cycle
//     idata, ddata - instruction/data words being written
//     sum          - accumulated checksum
module boot_checksum_acc
    import boot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_W-1:0]     idata,
    input  logic [DATA_W-1:0]     ddata,
    output logic [CHECKSUM_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + CHECKSUM_W'(idata) + CHECKSUM_W'(ddata);
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer
//   Streams each tile's instruction and data image from the boot image
//   memory into the array boot ports, one tile at a time, holding the
//   array in reset until all tiles are loaded.
//
//   Optional feature macro: BOOT_CHECKSUM_EN
//     defined   - boot_checksum accumulates every written word pair
//     undefined - no accumulator, boot_checksum tied to 0
//
//   Ports:
//     clk, reset         - single clock, synchronous active-high reset
//     start              - begin a boot (accepted in IDLE and DONE only)
//     img_addr           - image read address {tile, word}
//     img_idata/ddata    - image words, valid one cycle after img_addr
//     processor_select   - tile being loaded, NUM_PROCS when none
//     boot_iaddr/daddr   - write address (identical)
//     boot_idata/ddata   - write data (pass-through of image words)
//     boot_we            - write strobe
//     sys_resetn         - active-low array reset
//     busy, done         - progress status
//     boot_checksum      - image checksum (see macro above)
//     state              - current FSM state, for observation
//
//   Handshake: there is none; the image memory is assumed to answer every
//   address with data exactly one cycle later, so the write stage is a
//   single register stage of the issue strobe and word address.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int NUM_PROCS = DEF_NUM_PROCS,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORDS     = DEF_WORDS,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [SEL_W+ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0]       img_idata,
    input  logic [DATA_W-1:0]       img_ddata,
    output logic [SEL_W-1:0]        processor_select,
    output logic [ADDR_W-1:0]       boot_iaddr,
    output logic [DATA_W-1:0]       boot_idata,
    output logic [ADDR_W-1:0]       boot_daddr,
    output logic [DATA_W-1:0]       boot_ddata,
    output logic                    boot_we,
    output logic                    sys_resetn,
    output logic                    busy,
    output logic                    done,
    output logic [CHECKSUM_W-1:0]   boot_checksum,
    output boot_state_t             state
);

    localparam logic [SEL_W-1:0]  LAST_TILE = SEL_W'(NUM_PROCS - 1);
    localparam logic [SEL_W-1:0]  NO_TILE   = SEL_W'(NUM_PROCS);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    boot_state_t       state_n;
    logic [SEL_W-1:0]  tile, tile_n;
    logic [ADDR_W-1:0] word, word_n;
    logic              issue;

    // Write stage: one cycle behind the image read.
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tile    <= '0;
            word    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state <= state_n;
            tile  <= tile_n;
            word  <= word_n;
            we_q  <= issue;
            if (issue) begin
                waddr_q <= word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        tile_n  = tile;
        word_n  = word;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    tile_n  = '0;
                    word_n  = '0;
                end
            end
            ST_LOAD: begin
                if (word == LAST_WORD) begin
                    state_n = ST_DRAIN;
                    word_n  = '0;
                end else begin
                    word_n = word + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last word of the tile is written this cycle; the tile
                // counter only advances when another tile follows, so it
                // never passes NUM_PROCS-1.
                if (tile == LAST_TILE) begin
                    state_n = ST_RELEASE;
                end else begin
                    tile_n  = tile + 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                state_n = ST_DONE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        issue            = (state == ST_LOAD);
        img_addr         = issue ? {tile, word} : '0;
        processor_select = ((state == ST_LOAD) || (state == ST_DRAIN)) ? tile : NO_TILE;
        busy             = is_busy(state);
        done             = (state == ST_DONE);
        // Release is tied to DONE so a restart from DONE drops the array
        // reset on the very edge that accepts start.
        sys_resetn       = (state == ST_DONE);
    end

    assign boot_we    = we_q;
    assign boot_iaddr = waddr_q;
    assign boot_daddr = waddr_q;
    assign boot_idata = img_idata;
    assign boot_ddata = img_ddata;

`ifdef BOOT_CHECKSUM_EN
    logic start_ok;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    boot_checksum_acc #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .en    (we_q),
        .idata (img_idata),
        .ddata (img_ddata),
        .sum   (boot_checksum)
    );
`else
    assign boot_checksum = '0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer
//   Directed bench for boot_sequencer with NUM_PROCS=3, WORDS=4.
//   A per-cycle table describes one complete boot after start; it is
//   replayed for a cold boot, a restart from DONE, a boot with start
//   hammered during the load, a reload after a mid-boot reset, and a
//   boot with an all-ones image for the checksum.
`timescale 1ns/1ps
module tb_boot_sequencer;
    import boot_pkg::*;

    localparam int NP = 3;
    localparam int SW = 7;
    localparam int AW = 14;
    localparam int WD = 4;
    localparam int DW = 32;
    localparam int NSTEP = NP * (WD + 1) + 2;  // samples k = 0 .. 16

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [SW+AW-1:0] img_addr;
    logic [DW-1:0]    img_idata = '0;
    logic [DW-1:0]    img_ddata = '0;
    logic [SW-1:0]    processor_select;
    logic [AW-1:0]    boot_iaddr, boot_daddr;
    logic [DW-1:0]    boot_idata, boot_ddata;
    logic             boot_we, sys_resetn, busy, done;
    logic [31:0]      boot_checksum;
    boot_state_t      dut_state;

    always #5 clk = ~clk;

    boot_sequencer #(
        .NUM_PROCS (NP),
        .SEL_W     (SW),
        .ADDR_W    (AW),
        .WORDS     (WD),
        .DATA_W    (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .img_addr         (img_addr),
        .img_idata        (img_idata),
        .img_ddata        (img_ddata),
        .processor_select (processor_select),
        .boot_iaddr       (boot_iaddr),
        .boot_idata       (boot_idata),
        .boot_daddr       (boot_daddr),
        .boot_ddata       (boot_ddata),
        .boot_we          (boot_we),
        .sys_resetn       (sys_resetn),
        .busy             (busy),
        .done             (done),
        .boot_checksum    (boot_checksum),
        .state            (dut_state)
    );

    // ------------------------------------------------------------------
    // Image memory model: one-cycle read latency
    // ------------------------------------------------------------------
    bit ones_mode;

    function automatic logic [DW-1:0] img_i(input logic [SW+AW-1:0] a);
        return ones_mode ? DW'(1) : DW'(a);
    endfunction

    function automatic logic [DW-1:0] img_d(input logic [SW+AW-1:0] a);
        return ones_mode ? DW'(1) : (DW'(a) ^ 32'h5A00_0000);
    endfunction

    always @(posedge clk) begin
        img_idata <= img_i(img_addr);
        img_ddata <= img_d(img_addr);
    end

    // ------------------------------------------------------------------
    // Check helper and counters
    // ------------------------------------------------------------------
    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expected write data in order
    // ------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dq[$];
    bit            sb_on;

    always @(negedge clk) begin
        if (sb_on && boot_we) begin
            check("we_while_released", 32'(sys_resetn), 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra_write: got write at addr %0d, expected none", boot_iaddr);
            end else begin
                check("sb_idata", boot_idata, exp_q.pop_front());
                check("sb_ddata", boot_ddata, exp_dq.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle expectation table for one boot (k = cycles after E0)
    // ------------------------------------------------------------------
    typedef struct {
        logic [SW-1:0]    psel;
        logic             we;
        logic [AW-1:0]    waddr;
        logic [SW+AW-1:0] img;
        logic             busy;
        logic             done;
        logic             rn;
    } vec_t;

    vec_t tbl[NSTEP];

    function automatic vec_t mk(input int psel, input int we, input int waddr,
                                input int itile, input int iword, input int ion,
                                input int bsy, input int dn, input int rn);
        vec_t v;
        v.psel  = psel[SW-1:0];
        v.we    = we[0];
        v.waddr = waddr[AW-1:0];
        v.img   = (ion != 0) ? {itile[SW-1:0], iword[AW-1:0]} : '0;
        v.busy  = bsy[0];
        v.done  = dn[0];
        v.rn    = rn[0];
        return v;
    endfunction

    task automatic fill_table();
        //           psel we wa  it iw on  bs dn rn
        tbl[0]  = mk(0,   0, 0,  0, 0, 1,  1, 0, 0);
        tbl[1]  = mk(0,   1, 0,  0, 1, 1,  1, 0, 0);
        tbl[2]  = mk(0,   1, 1,  0, 2, 1,  1, 0, 0);
        tbl[3]  = mk(0,   1, 2,  0, 3, 1,  1, 0, 0);
        tbl[4]  = mk(0,   1, 3,  0, 0, 0,  1, 0, 0);
        tbl[5]  = mk(1,   0, 0,  1, 0, 1,  1, 0, 0);
        tbl[6]  = mk(1,   1, 0,  1, 1, 1,  1, 0, 0);
        tbl[7]  = mk(1,   1, 1,  1, 2, 1,  1, 0, 0);
        tbl[8]  = mk(1,   1, 2,  1, 3, 1,  1, 0, 0);
        tbl[9]  = mk(1,   1, 3,  0, 0, 0,  1, 0, 0);
        tbl[10] = mk(2,   0, 0,  2, 0, 1,  1, 0, 0);
        tbl[11] = mk(2,   1, 0,  2, 1, 1,  1, 0, 0);
        tbl[12] = mk(2,   1, 1,  2, 2, 1,  1, 0, 0);
        tbl[13] = mk(2,   1, 2,  2, 3, 1,  1, 0, 0);
        tbl[14] = mk(2,   1, 3,  0, 0, 0,  1, 0, 0);
        tbl[15] = mk(3,   0, 0,  0, 0, 0,  1, 0, 0);
        tbl[16] = mk(3,   0, 0,  0, 0, 0,  0, 1, 1);
    endtask

    // Caller raises start before calling; the first edge is E0.
    task automatic run_table(input bit noisy, input string tag);
        logic [31:0]      exp_sum;
        logic [31:0]      exp_cs;
        logic [SW+AW-1:0] a;
        exp_sum = '0;
        exp_q.delete();
        exp_dq.delete();
        for (int t = 0; t < NP; t++) begin
            for (int w = 0; w < WD; w++) begin
                a = {t[SW-1:0], w[AW-1:0]};
                exp_q.push_back(img_i(a));
                exp_dq.push_back(img_d(a));
                exp_sum = exp_sum + img_i(a) + img_d(a);
            end
        end
        sb_on = 1'b1;
        for (int k = 0; k < NSTEP; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                check($sformatf("%s_cs_clear", tag), boot_checksum, 32'd0);
            end
            check($sformatf("%s_k%0d_psel", tag, k), 32'(processor_select), 32'(tbl[k].psel));
            check($sformatf("%s_k%0d_we", tag, k), 32'(boot_we), 32'(tbl[k].we));
            check($sformatf("%s_k%0d_img_addr", tag, k), 32'(img_addr), 32'(tbl[k].img));
            check($sformatf("%s_k%0d_busy", tag, k), 32'(busy), 32'(tbl[k].busy));
            check($sformatf("%s_k%0d_done", tag, k), 32'(done), 32'(tbl[k].done));
            check($sformatf("%s_k%0d_resetn", tag, k), 32'(sys_resetn), 32'(tbl[k].rn));
            if (tbl[k].we) begin
                check($sformatf("%s_k%0d_iaddr", tag, k), 32'(boot_iaddr), 32'(tbl[k].waddr));
                check($sformatf("%s_k%0d_daddr", tag, k), 32'(boot_daddr), 32'(tbl[k].waddr));
            end
            if (k == 8) begin
                a = {7'd1, 14'd2};
                check($sformatf("%s_t1w2_idata", tag), boot_idata, img_i(a));
                check($sformatf("%s_t1w2_ddata", tag), boot_ddata, img_d(a));
            end
            start = (noisy && k < NSTEP - 1) ? k[0] : 1'b0;
        end
        sb_on = 1'b0;
        check($sformatf("%s_sb_left", tag), 32'(exp_q.size()), 32'd0);
`ifdef BOOT_CHECKSUM_EN
        exp_cs = exp_sum;
`else
        exp_cs = 32'd0;
`endif
        check($sformatf("%s_checksum", tag), boot_checksum, exp_cs);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(dut_state), 32'(ST_IDLE));
        check({tag, "_psel"}, 32'(processor_select), 32'd3);
        check({tag, "_img_addr"}, 32'(img_addr), 32'd0);
        check({tag, "_iaddr"}, 32'(boot_iaddr), 32'd0);
        check({tag, "_daddr"}, 32'(boot_daddr), 32'd0);
        check({tag, "_we"}, 32'(boot_we), 32'd0);
        check({tag, "_resetn"}, 32'(sys_resetn), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_checksum"}, boot_checksum, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        ones_mode = 1'b0;
        sb_on     = 1'b0;
        fill_table();

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");

        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_hold_state", 32'(dut_state), 32'(ST_IDLE));
        check("idle_hold_resetn", 32'(sys_resetn), 32'd0);

        // Cold boot.
        start = 1'b1;
        run_table(1'b0, "cold");

        // DONE holds; then restart from DONE.
        @(posedge clk);
        #1;
        check("done_hold_done", 32'(done), 32'd1);
        check("done_hold_psel", 32'(processor_select), 32'd3);
        start = 1'b1;
        run_table(1'b0, "reboot");

        // start pulsed repeatedly while busy must not disturb the sequence.
        @(posedge clk);
        #1;
        start = 1'b1;
        run_table(1'b1, "noisy");

        // Reset during tile 1, word 1, then reload from tile 0.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_pre_psel", 32'(processor_select), 32'd1);
        check("mid_pre_img_addr", 32'(img_addr), 32'({7'd1, 14'd1}));
        check("mid_pre_state", 32'(dut_state), 32'(ST_LOAD));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("mid_rst");
        reset = 1'b0;
        start = 1'b1;
        run_table(1'b0, "reload");

        // All-ones image: 12 writes of two words each.
        ones_mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        run_table(1'b0, "ones");
`ifdef BOOT_CHECKSUM_EN
        check("ones_checksum_24", boot_checksum, 32'd24);
`else
        check("ones_checksum_off", boot_checksum, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
